// File: rtl/data_port_arbiter_pkg.sv
// data_port_arbiter_pkg
// Shared definitions for the data RAM port arbiter: the sequencer state
// enum, the port index constants and the default bus widths.
package data_port_arbiter_pkg;

  localparam int DEFAULT_ADDR_W = 12;
  localparam int DEFAULT_DATA_W = 16;

  // Port 0 is the CPU load/store port, port 1 the DMA/debug master.
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RD_WAIT
  } arbStateT;

endpackage

// File: rtl/data_port_arbiter_if.sv
// data_port_arbiter_if
// Bundles both requester ports, the RAM-side lines and the status outputs
// of the data RAM arbiter.
//   slave  : the arbiter (takes requests and ram_din, drives grants/RAM lines)
//   master : the environment (requesters plus the RAM itself)
// Signals:
//   enable                      global grant enable
//   reqN/weN/addrN/wdataN/lockN request port N
//   gntN/rvalidN/wackN          one-cycle handshake pulses to port N
//   rdata                       shared read data, qualified by rvalidN
//   ram_sel/ram_ld/ram_addr/ram_dout/ram_din  single-port RAM lines
//   owner                       winner of the most recent arbitration
interface data_port_arbiter_if
  import data_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) ();

  logic              enable;
  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              lock0, lock1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic              wack0, wack1;
  logic [DATA_W-1:0] rdata;
  logic              ram_sel;
  logic              ram_ld;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dout;
  logic [DATA_W-1:0] ram_din;
  logic              owner;

  modport slave (
    input  enable, req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
           lock0, lock1, ram_din,
    output gnt0, gnt1, rvalid0, rvalid1, wack0, wack1, rdata,
           ram_sel, ram_ld, ram_addr, ram_dout, owner
  );

  modport master (
    output enable, req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
           lock0, lock1, ram_din,
    input  gnt0, gnt1, rvalid0, rvalid1, wack0, wack1, rdata,
           ram_sel, ram_ld, ram_addr, ram_dout, owner
  );

endinterface

// File: rtl/data_port_arbiter_rr.sv
// rr_arbiter2
// Combinational two-way round-robin picker with lock override.
//   eligible[1:0] : per-port "may be granted" flags
//   last_winner   : port granted most recently (loses a tie)
//   owner         : current owner, the only candidate while lock_owner is high
//   lock_owner    : the owner's lock input
//   win_valid     : some port wins this arbitration
//   win_idx       : the winning port
module rr_arbiter2
  import data_port_arbiter_pkg::*;
(
  input  logic [1:0] eligible,
  input  logic       last_winner,
  input  logic       owner,
  input  logic       lock_owner,
  output logic       win_valid,
  output logic       win_idx
);

  // A held lock narrows the choice to the owner alone, even if that leaves
  // nobody to grant; otherwise a tie goes to the port that did not win last.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = PORT_CPU;
    if (lock_owner) begin
      win_valid = eligible[owner];
      win_idx   = owner;
    end else if (eligible == 2'b11) begin
      win_valid = 1'b1;
      win_idx   = ~last_winner;
    end else if (eligible[PORT_CPU]) begin
      win_valid = 1'b1;
      win_idx   = PORT_CPU;
    end else if (eligible[PORT_AUX]) begin
      win_valid = 1'b1;
      win_idx   = PORT_AUX;
    end
  end

endmodule

// File: rtl/data_port_arbiter.sv
// data_port_arbiter
// Serialises two masters onto the single-port data RAM (one-cycle read
// latency). A won request is captured, driven onto the RAM in ACCESS, and
// answered with wackN in the same cycle (write) or rvalidN one cycle later
// in RD_WAIT (read).
//   clk    : clock, all state changes on posedge
//   reset  : asynchronous, active-high
//   bus    : data_port_arbiter_if.slave, requests in, grants/RAM lines out
module data_port_arbiter
  import data_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input logic                 clk,
  input logic                 reset,
  data_port_arbiter_if.slave  bus
);

  arbStateT          state, nextState;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] wdataQ;
  logic              weQ;
  logic              portQ;
  logic              ownerQ;
  logic              lastWinner;

  logic [1:0]        eligible;
  logic              lockOwner;
  logic              winValid;
  logic              winIdx;
  logic              arbPoint;

  assign eligible  = {bus.enable & bus.req1, bus.enable & bus.req0};
  assign lockOwner = (ownerQ == PORT_AUX) ? bus.lock1 : bus.lock0;

  // A read in ACCESS must go on to RD_WAIT; every other cycle is free to
  // pick the next access, which is what lets writes stream one per cycle
  // and reads follow each other without an IDLE bubble.
  assign arbPoint = (state != ACCESS) || weQ;

  rr_arbiter2 picker (
    .eligible    (eligible),
    .last_winner (lastWinner),
    .owner       (ownerQ),
    .lock_owner  (lockOwner),
    .win_valid   (winValid),
    .win_idx     (winIdx)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic.
  always_comb begin
    nextState = IDLE;
    case (state)
      ACCESS:  nextState = !weQ ? RD_WAIT : (winValid ? ACCESS : IDLE);
      IDLE,
      RD_WAIT: nextState = winValid ? ACCESS : IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Capture the winning request so the requester is free to move on as
  // soon as it sees its grant. lastWinner starts at port 1 so the very
  // first tie after reset goes to the CPU port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addrQ      <= '0;
      wdataQ     <= '0;
      weQ        <= 1'b0;
      portQ      <= PORT_CPU;
      ownerQ     <= PORT_CPU;
      lastWinner <= PORT_AUX;
    end else if (arbPoint && winValid) begin
      addrQ      <= (winIdx == PORT_AUX) ? bus.addr1  : bus.addr0;
      wdataQ     <= (winIdx == PORT_AUX) ? bus.wdata1 : bus.wdata0;
      weQ        <= (winIdx == PORT_AUX) ? bus.we1    : bus.we0;
      portQ      <= winIdx;
      ownerQ     <= winIdx;
      lastWinner <= winIdx;
    end
  end

  // Output decode. RAM address and write data come straight from the
  // capture registers, so no request input reaches the RAM combinationally.
  always_comb begin
    bus.gnt0     = 1'b0;
    bus.gnt1     = 1'b0;
    bus.wack0    = 1'b0;
    bus.wack1    = 1'b0;
    bus.rvalid0  = 1'b0;
    bus.rvalid1  = 1'b0;
    bus.ram_sel  = 1'b0;
    bus.ram_ld   = 1'b0;
    bus.rdata    = '0;
    bus.ram_addr = addrQ;
    bus.ram_dout = wdataQ;
    bus.owner    = ownerQ;
    case (state)
      ACCESS: begin
        bus.ram_sel = 1'b1;
        bus.ram_ld  = ~weQ;
        bus.gnt0    = (portQ == PORT_CPU);
        bus.gnt1    = (portQ == PORT_AUX);
        bus.wack0   = weQ && (portQ == PORT_CPU);
        bus.wack1   = weQ && (portQ == PORT_AUX);
      end
      RD_WAIT: begin
        bus.rdata   = bus.ram_din;
        bus.rvalid0 = (portQ == PORT_CPU);
        bus.rvalid1 = (portQ == PORT_AUX);
      end
      default: ;
    endcase
  end

endmodule

// File: doc/data_port_arbiter.md
# data_port_arbiter

Two-requester arbiter and sequencer for the single-port data RAM (12-bit address, 16-bit data, one-cycle synchronous read latency). It sits between the CPU load/store port (port 0) and a second master such as a DMA or debug loader (port 1). It serialises their accesses, drives the RAM select, load and address lines, and returns read data or a write acknowledge to the owning port. Grants are round-robin, and an optional lock holds ownership across multi-access sequences.

## Interface
- ADDR_W, 12, RAM address width
- DATA_W, 16, RAM data width
- clk  in  1  clock; all state changes on posedge
- reset  in  1  reset, asynchronous, active-high
- enable  in  1  global enable; low blocks new grants, in-flight access completes
- req0 / req1  in  1  access request, held until gnt pulse
- we0 / we1  in  1  1 = write, 0 = read; valid with req
- addr0 / addr1  in  ADDR_W  access address; valid with req
- wdata0 / wdata1  in  DATA_W  write data; valid with req
- lock0 / lock1  in  1  keep ownership after current access while high
- gnt0 / gnt1  out  1  one-cycle pulse: request accepted, inputs captured
- rvalid0 / rvalid1  out  1  one-cycle pulse: rdata valid for read
- wack0 / wack1  out  1  one-cycle pulse: write committed
- rdata  out  DATA_W  read data, shared; qualified by rvalidN
- ram_sel  out  1  RAM select
- ram_ld  out  1  1 = read, 0 = write; meaningful only with ram_sel
- ram_addr  out  ADDR_W  RAM address
- ram_dout  out  DATA_W  write data to RAM
- ram_din  in  DATA_W  read data from RAM, valid the cycle after ram_sel&ram_ld
- owner  out  1  port that won the most recent arbitration

## Operation
- FSM states: IDLE, ACCESS, RD_WAIT.
- Arbitration point: IDLE, ACCESS with a write, or RD_WAIT. The winner's request is captured and the FSM goes to ACCESS. With no eligible request, the FSM goes to IDLE.
- Eligibility: enable=1 and reqN=1. If the previous owner's lock is high, only the owner is eligible.
- Tie (both eligible, no lock): the port not granted last wins. last_winner resets to 1, so port 0 wins the first tie.
- ACCESS: ram_sel=1, ram_ld=~we_q, ram_addr=addr_q, ram_dout=wdata_q. gntN pulses in this cycle. A write asserts wackN in the same cycle. A read moves to RD_WAIT.
- RD_WAIT: rdata = ram_din, rvalidN=1, ram_sel=0.
- Requests are captured into registers, so the requester may change addr, we and wdata or drop req after gnt.
- owner updates at every grant. A lock is honoured only while it is asserted at the arbitration point. Dropping the lock re-enables round-robin at the next arbitration point.
- enable low at an arbitration point returns the FSM to IDLE. An access already in ACCESS or RD_WAIT completes.

## Timing
- Reset values: state IDLE, all gnt/rvalid/wack 0, ram_sel 0, ram_ld 0, ram_addr 0, ram_dout 0, rdata 0, owner 0, last_winner 1.
- Read: req at cycle 0 (IDLE), gnt and ram_sel at cycle 1, rvalid and rdata at cycle 2. Latency is 2 cycles, and back-to-back reads take 2 cycles each.
- Write: req at 0, gnt, ram_sel and wack at 1. Back-to-back writes sustain 1 per cycle.
- A request arriving in a RD_WAIT cycle is arbitrated in that cycle, and ACCESS follows immediately with no IDLE bubble.
- Reset asserted mid-access aborts the access: no rvalid or wack is issued, and all outputs go to reset values asynchronously.
- gnt is never asserted to both ports in one cycle, and ram_sel is never high in RD_WAIT or IDLE.
- ram_addr and ram_dout are registered, with no combinational path from req/addr inputs to RAM outputs.

## Structure
- Shared package data_port_arbiter_pkg holds:
  - the state enum {IDLE, ACCESS, RD_WAIT};
  - the port index constants PORT_CPU=0 and PORT_AUX=1;
  - the default ADDR_W and DATA_W.
- One sub-module, rr_arbiter2: the combinational two-way round-robin picker with lock/owner override. Inputs are eligible[1:0], last_winner, owner, lock_owner. Outputs are win_valid and win_idx.
- The top level holds the FSM, the capture registers and the output registers.

## Test plan
- Single read: port 0 reads addr 0x005, where RAM[0x005]=0xBEEF. gnt0 at cycle 1, rvalid0 with rdata=0xBEEF at cycle 2, no port-1 pulses.
- Concurrent writes after reset: req0 and req1 both write at cycle 0, to 0x010 (0x1111) and 0x011 (0x2222). Port 0 is granted at cycle 1 and port 1 at cycle 2. Both wacks fire, and RAM holds both values.
- Lock: port 1 holds lock1 and issues 3 writes while req0 is held. All 3 grants go to port 1, and gnt0 follows the cycle after the last write once lock1 drops.
- Reset mid-read: port 0 read granted, reset asserted in RD_WAIT. No rvalid0, all outputs 0, FSM in IDLE. The next tie goes to port 0.
- Enable gating: enable=0 with req0 held produces no gnt for 5 cycles. Raising enable gives gnt0 the next cycle. Lowering enable during RD_WAIT still delivers rvalid.
